// File: rtl/debounce_pkg.sv
// Shared types for the input-conditioning blocks: the debouncer FSM state encoding.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reusable by any input-conditioning block.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronises a bouncy mechanical input and only moves the output
// once the new level has been seen for STABLE_CYCLES consecutive samples.
module debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_raw,
  output logic db_level,
  output logic busy
);

  // A one-cycle qualification still needs a 1-bit counter to compare against.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic            sig_s;
  db_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_raw),
    .q     (sig_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Compare precedes increment, so cnt never passes CNT_LAST and cannot wrap.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ZERO: begin
        if (sig_s) begin
          state_nx = WAIT1;
          cnt_nx   = '0;
        end
      end
      WAIT1: begin
        if (!sig_s)               state_nx = ZERO;
        else if (cnt == CNT_LAST) state_nx = ONE;
        else                      cnt_nx   = cnt + 1'b1;
      end
      ONE: begin
        if (!sig_s) begin
          state_nx = WAIT0;
          cnt_nx   = '0;
        end
      end
      WAIT0: begin
        if (sig_s)                state_nx = ONE;
        else if (cnt == CNT_LAST) state_nx = ZERO;
        else                      cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = ZERO;
    endcase
  end

  assign db_level = (state == ONE)   || (state == WAIT0);
  assign busy     = (state == WAIT1) || (state == WAIT0);

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer with STABLE_CYCLES=4: directed scenarios plus randomized
// runs, each compared edge by edge against a run-length reference model.
module tb_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_raw;
  logic db_level;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Reference model: the synchronised sample is the raw input two edges late;
  // the output flips once the sample has disagreed with it for N+1 edges in a row.
  logic m_s1, m_s2, m_lvl;
  int   m_run;
  logic m_busy;

  debouncer #(.STABLE_CYCLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_raw  (sig_raw),
    .db_level (db_level),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic drive_edge(input logic raw, input logic rstn);
    logic v;
    sig_raw = raw;
    rst_n   = rstn;
    @(posedge clk);
    if (!rstn) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0;
    end else begin
      v = m_s2;
      if (v != m_lvl) begin
        m_run++;
        if (m_run == N + 1) begin
          m_lvl = ~m_lvl;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    m_busy = (m_run > 0);
    #1;
  endtask

  task automatic settle(input logic raw, input int n);
    for (int i = 0; i < n; i++) begin
      drive_edge(raw, 1'b1);
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL settle edge %0d: db_level=%b busy=%b expected %b %b", i, db_level, busy, m_lvl, m_busy);
      end
    end
  endtask

  task automatic test_reset();
    int first_hi = -1;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 1'b0);
      checks++;
      if (db_level !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: db_level=%b busy=%b expected 0 0", i, db_level, busy);
      end
    end
    for (int e = 1; e <= 10; e++) begin
      drive_edge(1'b1, 1'b1);
      if (db_level === 1'b1 && first_hi < 0) first_hi = e;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL reset_release edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (first_hi !== N + 3) begin
      errors++;
      $display("FAIL reset_release_latency: rose at edge %0d expected %0d", first_hi, N + 3);
    end
  endtask

  task automatic test_clean_press();
    int first_hi = -1, busy_n = 0;
    settle(1'b0, 10);
    for (int e = 1; e <= 12; e++) begin
      drive_edge(1'b1, 1'b1);
      if (busy === 1'b1) busy_n++;
      if (db_level === 1'b1 && first_hi < 0) first_hi = e;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL clean_press edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (first_hi !== N + 3) begin
      errors++;
      $display("FAIL clean_press_latency: rose at edge %0d expected %0d", first_hi, N + 3);
    end
    checks++;
    if (busy_n !== N) begin
      errors++;
      $display("FAIL clean_press_busy_len: %0d cycles expected %0d", busy_n, N);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat = 8'b1011_0111;
    int run = 0, max_run = 0;
    logic saw_hi = 1'b0;
    settle(1'b0, 10);
    for (int e = 0; e < 18; e++) begin
      drive_edge((e < 8) ? pat[e] : 1'b0, 1'b1);
      run = busy ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (db_level === 1'b1) saw_hi = 1'b1;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL bounce edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (saw_hi !== 1'b0 || max_run > 3) begin
      errors++;
      $display("FAIL bounce_summary: saw_hi=%b max_busy_run=%0d expected 0 and <=3", saw_hi, max_run);
    end
  endtask

  task automatic test_release_glitch();
    int first_lo = -1;
    logic dropped = 1'b0;
    settle(1'b1, 10);
    for (int e = 0; e < 11; e++) begin
      drive_edge((e < 3) ? 1'b0 : 1'b1, 1'b1);
      if (db_level !== 1'b1) dropped = 1'b1;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL glitch edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL glitch_hold: db_level dropped, expected to stay 1");
    end
    for (int e = 1; e <= 10; e++) begin
      drive_edge(1'b0, 1'b1);
      if (db_level === 1'b0 && first_lo < 0) first_lo = e;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL release edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (first_lo !== N + 3) begin
      errors++;
      $display("FAIL release_latency: fell at edge %0d expected %0d", first_lo, N + 3);
    end
  endtask

  task automatic test_reset_mid();
    int first_hi = -1;
    settle(1'b0, 10);
    // Edges 1-2 fill the synchroniser, edge 3 enters WAIT1, edges 4-5 count to 2.
    settle(1'b1, 5);
    drive_edge(1'b1, 1'b0);
    checks++;
    if (db_level !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: db_level=%b busy=%b expected 0 0", db_level, busy);
    end
    for (int e = 1; e <= 10; e++) begin
      drive_edge(1'b1, 1'b1);
      if (db_level === 1'b1 && first_hi < 0) first_hi = e;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL reset_mid_release edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (first_hi !== N + 3) begin
      errors++;
      $display("FAIL reset_mid_latency: rose at edge %0d expected %0d", first_hi, N + 3);
    end
  endtask

  task automatic test_spike();
    int busy_n = 0;
    logic saw_hi = 1'b0;
    settle(1'b0, 10);
    for (int e = 0; e < 10; e++) begin
      drive_edge((e == 0) ? 1'b1 : 1'b0, 1'b1);
      if (busy === 1'b1) busy_n++;
      if (db_level === 1'b1) saw_hi = 1'b1;
      checks++;
      if (db_level !== m_lvl || busy !== m_busy) begin
        errors++;
        $display("FAIL spike edge %0d: db_level=%b busy=%b expected %b %b", e, db_level, busy, m_lvl, m_busy);
      end
    end
    checks++;
    if (busy_n !== 1 || saw_hi !== 1'b0) begin
      errors++;
      $display("FAIL spike_summary: busy_cycles=%0d saw_hi=%b expected 1 and 0", busy_n, saw_hi);
    end
  endtask

  task automatic test_random();
    logic raw = 1'b0;
    logic rstn;
    int hold;
    for (int seg = 0; seg < 150; seg++) begin
      raw  = ~raw;
      hold = $urandom_range(1, 9);
      for (int i = 0; i < hold; i++) begin
        rstn = ($urandom_range(0, 99) != 0);
        drive_edge(raw, rstn);
        checks++;
        if (db_level !== m_lvl || busy !== m_busy) begin
          errors++;
          $display("FAIL random seg %0d: db_level=%b busy=%b expected %b %b", seg, db_level, busy, m_lvl, m_busy);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    sig_raw = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_busy = 1'b0;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid();
    test_spike();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
